kbd_event_sequencer: RTL

Sits between the Pi command interface and the keyboard matrix block. It accepts discrete key make/break events from the Pi into a FIFO and keeps a shadow copy of the 10-row key matrix. For each event it issues one row write to the matrix, then holds off the next event until the PET CPU has scanned that row, so fast typing is never lost. It also arbitrates the matrix write port between these sequenced writes and raw Pi row writes.

---
 rtl/kbd_event_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_sequencer.sv
// Queues Pi key make/break events, keeps a shadow of the 10-row key matrix
// and paces matrix row writes so every change is seen by a CPU scan.
module kbd_event_sequencer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int MIN_SCANS    = 2,
    parameter int HOLD_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [3:0]  evt_row,
    input  logic [2:0]  evt_col,
    input  logic        evt_make,
    input  logic        evt_clear,
    input  logic [15:0] pi_addr,
    input  logic [7:0]  pi_data,
    input  logic        pi_write_strobe,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_data_in,
    input  logic        pia1_enabled_in,
    input  logic        cpu_write_strobe,
    output logic [15:0] kbd_addr,
    output logic [7:0]  kbd_data,
    output logic        kbd_write_strobe,
    output logic [4:0]  fifo_count,
    output logic        busy,
    output logic        err_bad_row
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(HOLD_TIMEOUT);
    localparam int SW = $clog2(MIN_SCANS + 1) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD, CLEAR} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shadow [10];
    logic [3:0]    cur_row;
    logic [2:0]    cur_col;
    logic          cur_make;
    logic [3:0]    clr_row;
    logic [SW-1:0] scan_cnt;
    logic [TW-1:0] timer;

    logic [7:0] head;
    logic [3:0] head_row;
    logic       head_ok;
    logic [7:0] head_val;
    logic [7:0] wr_val;
    logic       push, pop;
    logic       pi_hit, scan_hit;
    logic       seq_go, clr_go;
    logic       unused_hi;

    // Make clears the key bit (pressed = 0), release sets it.
    function automatic logic [7:0] apply(input logic [7:0] val,
                                         input logic [2:0] col,
                                         input logic       make);
        logic [7:0] m;
        m = 8'h01 << col;
        return make ? (val & ~m) : (val | m);
    endfunction

    assign head     = mem[rd_ptr];
    assign head_row = head[7:4];
    assign head_ok  = head_row <= 4'd9;
    assign head_val = apply(shadow[head_row], head[3:1], head[0]);
    // Re-read the shadow so a raw write that landed during a stall is merged.
    assign wr_val   = apply(shadow[cur_row], cur_col, cur_make);

    assign evt_ready = count < CW'(FIFO_DEPTH);
    assign push      = evt_valid && evt_ready && !evt_clear;
    assign pop       = (state == IDLE) && (count != '0) && !evt_clear;
    assign pi_hit    = pi_write_strobe && (pi_addr[15:4] == 12'hE80)
                       && (pi_addr[3:0] <= 4'd9);
    assign scan_hit  = cpu_write_strobe && pia1_enabled_in
                       && (bus_addr == 2'd0) && (bus_data_in[3:0] == cur_row);
    assign seq_go    = (state == WRITE) && !pi_write_strobe && !evt_clear;
    assign clr_go    = (state == CLEAR) && !pi_write_strobe && !evt_clear;

    assign fifo_count = 5'(count);
    assign busy       = (state != IDLE) || (count != '0);
    assign unused_hi  = ^bus_data_in[7:4];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and matrix write port mux; raw Pi writes win the port.
    always_comb begin
        state_nx         = state;
        kbd_addr         = 16'h0000;
        kbd_data         = 8'h00;
        kbd_write_strobe = 1'b0;
        unique case (state)
            IDLE:  if (pop && head_ok) state_nx = WRITE;
            WRITE: if (!pi_write_strobe) state_nx = HOLD;
            HOLD:  if (scan_cnt == SW'(MIN_SCANS) ||
                       timer == TW'(HOLD_TIMEOUT - 1)) state_nx = IDLE;
            CLEAR: if (!pi_write_strobe && clr_row == 4'd9) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (evt_clear) state_nx = CLEAR;
        if (reset_b) begin
            if (pi_write_strobe) begin
                kbd_addr         = pi_addr;
                kbd_data         = pi_data;
                kbd_write_strobe = 1'b1;
            end else if (seq_go) begin
                kbd_addr         = {12'hE80, cur_row};
                kbd_data         = wr_val;
                kbd_write_strobe = 1'b1;
            end else if (clr_go) begin
                kbd_addr         = {12'hE80, clr_row};
                kbd_data         = 8'hFF;
                kbd_write_strobe = 1'b1;
            end
        end
    end

    // Event FIFO storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {evt_row, evt_col, evt_make};
    end

    // FIFO pointers, current event, scan pacing and error flag.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_bad_row <= 1'b0;
            cur_row     <= 4'd0;
            cur_col     <= 3'd0;
            cur_make    <= 1'b0;
            clr_row     <= 4'd0;
            scan_cnt    <= '0;
            timer       <= '0;
        end else if (evt_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            clr_row <= 4'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop && !head_ok) err_bad_row <= 1'b1;
            if (pop && head_ok) begin
                cur_row  <= head_row;
                cur_col  <= head[3:1];
                cur_make <= head[0];
            end
            if (state == WRITE) begin
                scan_cnt <= '0;
                timer    <= '0;
            end else if (state == HOLD) begin
                timer <= timer + TW'(1);
                if (scan_hit) scan_cnt <= scan_cnt + SW'(1);
            end
            if (clr_go) clr_row <= clr_row + 4'd1;
        end
    end

    // Shadow matrix: event updates, then raw Pi row writes on top.
    always_ff @(posedge clk) begin
        if (!reset_b || evt_clear) begin
            for (int i = 0; i < 10; i++) shadow[i] <= 8'hFF;
        end else begin
            if (pop && head_ok) shadow[head_row] <= head_val;
            if (seq_go) shadow[cur_row] <= wr_val;
            if (pi_hit) shadow[pi_addr[3:0]] <= pi_data;
        end
    end
endmodule
